// File: rtl/mul32_shiftadd.sv
// Sequential 32x32 unsigned shift-add multiplier.
// One partial product per cycle through sll32; sticky exact overflow.

module sll32 (
  input  logic [31:0] a,
  input  logic [4:0]  sh,
  output logic [31:0] y,
  output logic        cout
);

  logic [63:0] w_wide;

  // widen before shifting so dropped bits stay visible for cout
  always_comb begin
    w_wide = {32'd0, a} << sh;
    y      = w_wide[31:0];
    cout   = |w_wide[63:32];
  end

endmodule

module mul32_shiftadd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_ma;
  logic [31:0] r_mb;
  logic [31:0] r_acc;
  logic        r_ovf_s;
  logic [4:0]  r_idx;

  logic [31:0] w_shifted;
  logic        w_cout;
  logic [32:0] w_sum;
  logic        w_sel;
  logic        w_last;
  logic [31:0] w_acc_nxt;
  logic        w_ovf_nxt;

  sll32 u_sll (
    .a    (r_ma),
    .sh   (r_idx),
    .y    (w_shifted),
    .cout (w_cout)
  );

  // one step of the shift-add recurrence
  always_comb begin
    w_sum     = {1'b0, r_acc} + {1'b0, w_shifted};
    w_sel     = r_mb[r_idx];
    w_last    = (r_idx == 5'd31);
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf_s;
    if (w_sel) begin
      w_acc_nxt = w_sum[31:0];
      w_ovf_nxt = r_ovf_s | w_cout | w_sum[32];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ma    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_ovf_s <= 1'b0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      busy <= (w_state_nxt == S_RUN);
      done <= (w_state_nxt == S_DONE);
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_ma    <= a;
            r_mb    <= b;
            r_acc   <= '0;
            r_ovf_s <= 1'b0;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_ovf_s <= w_ovf_nxt;
          r_idx   <= r_idx + 5'd1;
          if (w_last) begin
            product <= w_acc_nxt;
            ovf     <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_shiftadd.sv
// Randomized bench for mul32_shiftadd.
// Reference result comes from a plain 64-bit multiply.

module tb_mul32_shiftadd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  int n_err;
  int n_chk;

  logic [31:0] prev_p;
  logic        prev_o;

  mul32_shiftadd dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // caller is at a negedge; returns at the negedge of the done cycle
  task automatic do_op(input logic [31:0] ia,
                       input logic [31:0] ib,
                       input bit          mid);
    logic [63:0] full;
    int          nbusy;
    int          ndone;
    full  = {32'd0, ia} * {32'd0, ib};
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    nbusy = 0;
    ndone = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (busy)  nbusy++;
      if (done)  ndone++;
      if (k == 1) begin
        chk("hold_p", product, prev_p);
        chk("hold_o", {31'd0, ovf}, {31'd0, prev_o});
      end
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      if (mid && k == 5) start = 1'b1;
    end
    chk("busy_cyc", nbusy, 32);
    chk("done_early", ndone, 0);
    @(negedge clk);
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_off", {31'd0, busy}, 32'd0);
    chk("product", product, full[31:0]);
    chk("ovf", {31'd0, ovf}, {31'd0, |full[63:32]});
    prev_p = full[31:0];
    prev_o = |full[63:32];
  endtask

  task automatic idle_gap();
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    n_err  = 0;
    n_chk  = 0;
    prev_p = '0;
    prev_o = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_prod", product, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'd3, 32'd5, 1'b0);            idle_gap();
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);    idle_gap();
    do_op(32'hFFFF_FFFF, 32'd2, 1'b0);    idle_gap();
    do_op(32'h6000_0000, 32'd3, 1'b0);    idle_gap();
    do_op(32'h0001_0000, 32'h0001_0000, 1'b0); idle_gap();
    do_op(32'h1234, 32'd0, 1'b0);         idle_gap();
    do_op(32'h0000_00FF, 32'h0000_0101, 1'b1); idle_gap();

    // back-to-back: second start issued in the done cycle
    do_op(32'd7, 32'd9, 1'b0);
    do_op(32'hDEAD_BEEF, 32'h0000_0010, 1'b0);
    idle_gap();

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb & 32'h0000_FFFF;
      if (i % 5 == 0) ra = ra & 32'h0000_0FFF;
      do_op(ra, rb, (i % 4) == 1);
      if (i % 2 == 0) idle_gap();
    end
    idle_gap();

    // reset in the middle of a run
    start = 1'b1;
    a     = 32'h0000_1111;
    b     = 32'h0000_0003;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_prod", product, 32'd0);
    chk("mrst_ovf", {31'd0, ovf}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mrst_quiet", ndone, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
